// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial unsigned adder. Two parallel-loaded WIDTH-bit
//                operands plus a carry-in are summed LSB-first, one bit per
//                clock, through a single full-adder cell and a carry flop.
//                A start/done handshake frames each addition. Latency is
//                WIDTH+1 edges from the accepting edge to done.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must be able to index every bit position of the operand.
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opa_q,   opa_d;
  logic [WIDTH-1:0]  opb_q,   opb_d;
  logic [WIDTH-1:0]  acc_q,   acc_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [WIDTH-1:0]  sum_q,   sum_d;
  logic              cout_q,  cout_d;

  // Full-adder cell operating on the current LSBs and the stored carry.
  logic              w_bit_sum;
  logic              w_bit_carry;
  logic [WIDTH-1:0]  w_acc_shift;

  // Single full-adder cell plus the accumulator shifted with the new bit at the MSB.
  always_comb begin
    w_bit_sum   = opa_q[0] ^ opb_q[0] ^ carry_q;
    w_bit_carry = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    // Written as a shift/OR so it also degenerates cleanly to WIDTH=1.
    w_acc_shift = (acc_q >> 1) | (WIDTH'(w_bit_sum) << (WIDTH - 1));
  end

  // Next-state and datapath update; outputs only change on the edge entering DONE.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = w_bit_carry;
        acc_d   = w_acc_shift;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Final bit bypasses the accumulator straight into the result.
          sum_d   = w_acc_shift;
          cout_d  = w_bit_carry;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // One-cycle completion state; start is deliberately not looked at.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed and randomised checks of serial_adder at WIDTH=8
//                and WIDTH=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       u1_start, u1_cin;
  logic [0:0] u1_a, u1_b;
  logic       u1_busy, u1_done, u1_cout;
  logic [0:0] u1_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(u1_start), .a(u1_a), .b(u1_b), .cin(u1_cin),
    .busy(u1_busy), .done(u1_done), .sum(u1_sum), .cout(u1_cout)
  );

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((busy && done) || (u1_busy && u1_done)) begin
        errors++;
        $display("FAIL busy_done_overlap w8 busy=%b done=%b w1 busy=%b done=%b required not both 1",
                 busy, done, u1_busy, u1_done);
      end
    end
  end

  // One WIDTH=8 operation; returns at the negedge where done is seen.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output logic [7:0] s, output logic co, output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout;
    if (!done) begin
      checks++; errors++;
      $display("FAIL w8_timeout done=%b after %0d edges required done=1", done, lat);
    end
  endtask

  task automatic run_op1(input logic ta, input logic tb_v, input logic tc,
                         output logic s, output logic co, output int lat, output int bcnt);
    @(negedge clk);
    u1_a = ta; u1_b = tb_v; u1_cin = tc; u1_start = 1'b1;
    @(negedge clk);
    u1_start = 1'b0;
    lat = 1; bcnt = 0;
    while (!u1_done && lat < 20) begin
      if (u1_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    s = u1_sum[0]; co = u1_cout;
    if (!u1_done) begin
      checks++; errors++;
      $display("FAIL w1_timeout done=%b after %0d edges required done=1", u1_done, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    u1_start = 1'b0; u1_a = '0; u1_b = '0; u1_cin = 1'b0;
    #2;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_w8 busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    checks++;
    if ({u1_busy, u1_done, u1_sum, u1_cout} !== 4'd0) begin
      errors++;
      $display("FAIL reset_w1 busy=%b done=%b sum=%b cout=%b required all 0",
               u1_busy, u1_done, u1_sum, u1_cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [7:0] s; logic co; int lat, bcnt;
    run_op8(8'h00, 8'h00, 1'b0, s, co, lat, bcnt);
    checks++;
    if ({co, s} !== 9'h000) begin
      errors++; $display("FAIL zero_sum got %h required 000", {co, s});
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL zero_latency got %0d required 9", lat);
    end
    checks++;
    if (bcnt !== 8) begin
      errors++; $display("FAIL zero_busy_cycles got %0d required 8", bcnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h5A};
    logic [7:0] vb [3] = '{8'h01, 8'h01, 8'hA5};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] ve [3] = '{9'h100, 9'h080, 9'h100};
    logic [7:0] s; logic co; int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      run_op8(va[i], vb[i], vc[i], s, co, lat, bcnt);
      checks++;
      if ({co, s} !== ve[i]) begin
        errors++;
        $display("FAIL vector_%0d got {cout,sum}=%h required %h", i, {co, s}, ve[i]);
      end
    end
  endtask

  task automatic test_start_during_run();
    int lat, dones, lat_done;
    logic [7:0] s; logic co;
    dones = 0; lat_done = 0; s = '0; co = 1'b0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0; a = 8'hC3; b = 8'h3C;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        dones++;
        if (dones == 1) begin lat_done = lat; s = sum; co = cout; end
      end
      @(negedge clk); lat++;
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL midrun_done_count got %0d required 1", dones);
    end
    checks++;
    if ({co, s} !== 9'h046) begin
      errors++; $display("FAIL midrun_sum got %h required 046", {co, s});
    end
    checks++;
    if (lat_done !== 9) begin
      errors++; $display("FAIL midrun_latency got %0d required 9", lat_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic co; int lat, bcnt;
    run_op8(8'h40, 8'h04, 1'b0, s, co, lat, bcnt);
    checks++;
    if ({co, s} !== 9'h044) begin
      errors++; $display("FAIL b2b_first got %h required 044", {co, s});
    end
    // Still in the DONE cycle: this request must be ignored.
    a = 8'hAA; b = 8'hAA; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_done_ignore busy=%b done=%b required 0 0", busy, done);
    end
    a = 8'h01; b = 8'h02; cin = 1'b0;
    @(negedge clk);
    start = 1'b0; lat = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept busy=%b required 1", busy);
    end
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if ({cout, sum} !== 9'h003 || lat !== 9) begin
      errors++;
      $display("FAIL b2b_second got %h lat %0d required 003 lat 9", {cout, sum}, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] s; logic co; int lat, bcnt;
    run_op8(8'hF0, 8'h20, 1'b0, s, co, lat, bcnt);
    checks++;
    if ({co, s} !== 9'h110) begin
      errors++; $display("FAIL areset_pre got %h required 110", {co, s});
    end
    @(negedge clk);
    a = 8'h99; b = 8'h66; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL areset_busy_before busy=%b required 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL areset_clear busy=%b done=%b sum=%h cout=%b required all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'h10, 8'h20, 1'b0, s, co, lat, bcnt);
    checks++;
    if ({co, s} !== 9'h030 || lat !== 9) begin
      errors++; $display("FAIL areset_after got %h lat %0d required 030 lat 9", {co, s}, lat);
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] ra, rb, s; logic rc, co; int lat, bcnt; logic [8:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op8(ra, rb, rc, s, co, lat, bcnt);
      checks++;
      if ({co, s} !== exp_v || lat !== 9) begin
        errors++;
        $display("FAIL rand_w8 %h+%h+%b got %h lat %0d required %h lat 9", ra, rb, rc, {co, s}, lat, exp_v);
      end
    end
  endtask

  task automatic test_random_w1();
    logic ra, rb, rc, s, co; int lat, bcnt; logic [1:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {1'b0, rc};
      run_op1(ra, rb, rc, s, co, lat, bcnt);
      checks++;
      if ({co, s} !== exp_v || lat !== 2 || bcnt !== 1) begin
        errors++;
        $display("FAIL rand_w1 %b+%b+%b got %b lat %0d busy %0d required %b lat 2 busy 1",
                 ra, rb, rc, {co, s}, lat, bcnt, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_start_during_run();
    test_back_to_back();
    test_async_reset();
    test_random_w8();
    test_random_w1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
